// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives datapath strobes from the current state, stalls on handshakes and traps on timeouts.
module multicycle_control_fsm #(
  parameter int OPCODE_W   = 6,
  parameter int MEM_TO_MAX = 15,
  parameter int CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                in_valid,
  input  logic                out_ready,
  input  logic                resume,
  output logic                ir_write,
  output logic                pc_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [2:0]          mem_to_reg,
  output logic [1:0]          jump,
  output logic [2:0]          alu_op,
  output logic                alu_src,
  output logic                in_ack,
  output logic                out_valid,
  output logic                halted,
  output logic                end_of_proc,
  output logic                illegal_op,
  output logic                bus_error,
  output logic [CNT_W-1:0]    retired
);

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_JR   = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_IN   = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_OUT  = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_ENDP = OPCODE_W'(62);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(63);

  // The counter only has to hold 0..MEM_TO_MAX-1; the last not-ready cycle traps instead.
  localparam int                WAIT_W    = (MEM_TO_MAX > 1) ? $clog2(MEM_TO_MAX) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TO_MAX - 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_IO,
    S_HALTED,
    S_TRAP
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                retire;

  function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_ADDI, OP_SUBI, OP_BEQ, OP_J, OP_JR, OP_JAL,
      OP_IN, OP_OUT, OP_ENDP, OP_HALT: op_legal = 1'b1;
      default:                         op_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    op_d    = op_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_HALT: begin
            state_d = S_HALTED;
            retire  = 1'b1;
          end
          OP_ENDP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          OP_IN, OP_OUT: state_d = S_IO;
          OP_R, OP_LW, OP_SW, OP_ADDI, OP_SUBI, OP_BEQ, OP_J, OP_JR, OP_JAL:
            state_d = S_EXEC;
          default: state_d = S_FETCH;
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_BEQ, OP_J, OP_JR, OP_JAL: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (op_q == OP_SW) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_IO: begin
        // No timeout here: peripherals may stall indefinitely.
        if ((op_q == OP_IN) ? in_valid : out_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_HALTED, S_TRAP: begin
        if (resume) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
    if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q) begin
      wait_d = '0;
    end
    retired_d = retired_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

  // Strobes are gated by rst_n so an asserted reset silences the datapath immediately.
  always_comb begin
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 2'b00;
    mem_to_reg  = 3'b000;
    jump        = 2'b00;
    alu_op      = 3'b000;
    alu_src     = 1'b0;
    in_ack      = 1'b0;
    out_valid   = 1'b0;
    halted      = 1'b0;
    end_of_proc = 1'b0;
    illegal_op  = 1'b0;
    bus_error   = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          ir_write = imem_ready;
          pc_write = imem_ready;
        end
        S_DECODE: begin
          end_of_proc = (opcode == OP_ENDP);
          illegal_op  = !op_legal(opcode);
        end
        S_EXEC: begin
          case (op_q)
            OP_R: alu_op = 3'b100;
            OP_LW, OP_SW, OP_ADDI: begin
              alu_op  = 3'b000;
              alu_src = 1'b1;
            end
            OP_SUBI: begin
              alu_op  = 3'b001;
              alu_src = 1'b1;
            end
            OP_BEQ: begin
              alu_op   = 3'b011;
              pc_write = alu_zero;
            end
            OP_J: begin
              jump     = 2'b01;
              pc_write = 1'b1;
            end
            OP_JR: begin
              jump     = 2'b10;
              pc_write = 1'b1;
            end
            OP_JAL: begin
              jump       = 2'b01;
              pc_write   = 1'b1;
              reg_dst    = 2'b10;
              mem_to_reg = 3'b010;
              reg_write  = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_read  = (op_q == OP_LW);
          mem_write = (op_q == OP_SW);
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = (op_q == OP_R) ? 2'b01 : 2'b00;
          mem_to_reg = (op_q == OP_LW) ? 3'b001 : 3'b000;
        end
        S_IO: begin
          if (op_q == OP_IN) begin
            if (in_valid) begin
              in_ack     = 1'b1;
              reg_write  = 1'b1;
              reg_dst    = 2'b11;
              mem_to_reg = 3'b011;
            end
          end else begin
            out_valid = 1'b1;
          end
        end
        S_HALTED: halted    = 1'b1;
        S_TRAP:   bus_error = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed per-cycle vectors pushed to a scoreboard,
// popped and compared by a negedge monitor.
module tb_multicycle_control_fsm;

  localparam int OPCODE_W = 6;
  localparam int CNT_W    = 32;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [OPCODE_W-1:0] opcode;
  logic                alu_zero, imem_ready, dmem_ready, in_valid, out_ready, resume;
  logic                ir_write, pc_write, mem_read, mem_write, reg_write;
  logic [1:0]          reg_dst, jump;
  logic [2:0]          mem_to_reg, alu_op;
  logic                alu_src, in_ack, out_valid, halted, end_of_proc, illegal_op, bus_error;
  logic [CNT_W-1:0]    retired;

  always #5 clk = ~clk;

  multicycle_control_fsm #(
    .OPCODE_W  (OPCODE_W),
    .MEM_TO_MAX(15),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .alu_zero   (alu_zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .in_valid   (in_valid),
    .out_ready  (out_ready),
    .resume     (resume),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .jump       (jump),
    .alu_op     (alu_op),
    .alu_src    (alu_src),
    .in_ack     (in_ack),
    .out_valid  (out_valid),
    .halted     (halted),
    .end_of_proc(end_of_proc),
    .illegal_op (illegal_op),
    .bus_error  (bus_error),
    .retired    (retired)
  );

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [2:0] mem_to_reg;
    logic [1:0] jump;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       in_ack;
    logic       out_valid;
    logic       halted;
    logic       end_of_proc;
    logic       illegal_op;
    logic       bus_error;
  } outs_t;

  typedef struct {
    outs_t            o;
    logic [CNT_W-1:0] r;
    string            nm;
  } exp_t;

  outs_t act;
  assign act = {ir_write, pc_write, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
                jump, alu_op, alu_src, in_ack, out_valid, halted, end_of_proc,
                illegal_op, bus_error};

  exp_t sb_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: one scoreboard entry per cycle, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        cur = sb_q.pop_front();
        n_cmp++;
        if (act !== cur.o) begin
          n_bad++;
          $display("FAIL %s strobes: got %h required %h", cur.nm, act, cur.o);
        end
        n_cmp++;
        if (retired !== cur.r) begin
          n_bad++;
          $display("FAIL %s retired: got %0d required %0d", cur.nm, retired, cur.r);
        end
        $display("txn %-16s strobes=%h retired=%0d", cur.nm, act, retired);
      end
    end
  end

  function automatic outs_t o_fetch(input logic rdy);
    outs_t o;
    o          = '0;
    o.mem_read = 1'b1;
    o.ir_write = rdy;
    o.pc_write = rdy;
    return o;
  endfunction

  function automatic outs_t o_alu(input logic [2:0] op, input logic src);
    outs_t o;
    o         = '0;
    o.alu_op  = op;
    o.alu_src = src;
    return o;
  endfunction

  function automatic outs_t o_wb(input logic [1:0] dst, input logic [2:0] m2r);
    outs_t o;
    o            = '0;
    o.reg_write  = 1'b1;
    o.reg_dst    = dst;
    o.mem_to_reg = m2r;
    return o;
  endfunction

  task automatic step(input outs_t e, input logic [CNT_W-1:0] r, input string nm);
    exp_t x;
    x.o  = e;
    x.r  = r;
    x.nm = nm;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic front(input logic [OPCODE_W-1:0] op, input logic [CNT_W-1:0] r,
                       input string tag);
    opcode     = op;
    imem_ready = 1'b1;
    step(o_fetch(1'b1), r, {tag, "/fetch"});
    step('0, r, {tag, "/decode"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end, required completion");
    $fatal(1);
  end

  initial begin
    outs_t e;
    rst_n      = 1'b0;
    opcode     = '0;
    alu_zero   = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    resume     = 1'b0;
    @(posedge clk);
    #1;
    step('0, 0, "reset");
    rst_n = 1'b1;

    // addi with memories always ready: four cycles, one retire.
    dmem_ready = 1'b1;
    front(3, 0, "addi");
    step(o_alu(3'b000, 1'b1), 0, "addi/exec");
    step(o_wb(2'b00, 3'b000), 0, "addi/wb");

    // lw with dmem_ready arriving on the fourth MEM cycle.
    dmem_ready = 1'b0;
    front(1, 1, "lw");
    step(o_alu(3'b000, 1'b1), 1, "lw/exec");
    e = '0;
    e.mem_read = 1'b1;
    repeat (3) step(e, 1, "lw/mem_wait");
    dmem_ready = 1'b1;
    step(e, 1, "lw/mem_rdy");
    step(o_wb(2'b00, 3'b001), 1, "lw/wb");

    // beq taken then not taken.
    alu_zero = 1'b1;
    front(5, 2, "beq1");
    e = o_alu(3'b011, 1'b0);
    e.pc_write = 1'b1;
    step(e, 2, "beq1/exec");
    alu_zero = 1'b0;
    front(5, 3, "beq0");
    step(o_alu(3'b011, 1'b0), 3, "beq0/exec");

    // sw with dmem_ready never arriving: 15 MEM cycles then TRAP.
    dmem_ready = 1'b0;
    front(2, 4, "sw_to");
    step(o_alu(3'b000, 1'b1), 4, "sw_to/exec");
    e = '0;
    e.mem_write = 1'b1;
    repeat (15) step(e, 4, "sw_to/mem");
    e = '0;
    e.bus_error = 1'b1;
    repeat (2) step(e, 4, "trap");
    resume = 1'b1;
    step(e, 4, "trap/resume");
    resume = 1'b0;

    // sw with ready exactly on the limit cycle: completes instead of trapping.
    front(2, 4, "sw_lim");
    step(o_alu(3'b000, 1'b1), 4, "sw_lim/exec");
    e = '0;
    e.mem_write = 1'b1;
    repeat (14) step(e, 4, "sw_lim/mem");
    dmem_ready = 1'b1;
    step(e, 4, "sw_lim/mem_rdy");
    dmem_ready = 1'b0;

    // out: one fetch stall, then out_ready after five cycles.
    opcode     = 13;
    imem_ready = 1'b0;
    step(o_fetch(1'b0), 5, "out/fetch_wait");
    front(13, 5, "out");
    e = '0;
    e.out_valid = 1'b1;
    repeat (5) step(e, 5, "out/wait");
    out_ready = 1'b1;
    step(e, 5, "out/accept");
    out_ready = 1'b0;

    // in: two idle cycles then the word arrives.
    front(12, 6, "in");
    repeat (2) step('0, 6, "in/wait");
    in_valid = 1'b1;
    e = '0;
    e.in_ack     = 1'b1;
    e.reg_write  = 1'b1;
    e.reg_dst    = 2'b11;
    e.mem_to_reg = 3'b011;
    step(e, 6, "in/accept");
    in_valid = 1'b0;

    // Jumps.
    front(11, 7, "jal");
    e = '0;
    e.jump       = 2'b01;
    e.pc_write   = 1'b1;
    e.reg_dst    = 2'b10;
    e.mem_to_reg = 3'b010;
    e.reg_write  = 1'b1;
    step(e, 7, "jal/exec");
    front(10, 8, "jr");
    e = '0;
    e.jump     = 2'b10;
    e.pc_write = 1'b1;
    step(e, 8, "jr/exec");
    front(9, 9, "j");
    e = '0;
    e.jump     = 2'b01;
    e.pc_write = 1'b1;
    step(e, 9, "j/exec");

    // R-type and subi write-back paths.
    front(0, 10, "rtype");
    step(o_alu(3'b100, 1'b0), 10, "rtype/exec");
    step(o_wb(2'b01, 3'b000), 10, "rtype/wb");
    front(4, 11, "subi");
    step(o_alu(3'b001, 1'b1), 11, "subi/exec");
    step(o_wb(2'b00, 3'b000), 11, "subi/wb");

    // Undefined opcode 7 (resume is ignored in DECODE).
    opcode     = 7;
    imem_ready = 1'b1;
    step(o_fetch(1'b1), 12, "illegal/fetch");
    resume = 1'b1;
    e = '0;
    e.illegal_op = 1'b1;
    step(e, 12, "illegal/decode");
    resume = 1'b0;

    // EndProcess retires from DECODE.
    opcode = 62;
    step(o_fetch(1'b1), 12, "endp/fetch");
    e = '0;
    e.end_of_proc = 1'b1;
    step(e, 12, "endp/decode");

    // halt retires on entry to HALTED and stays until resume.
    front(63, 13, "halt");
    e = '0;
    e.halted = 1'b1;
    repeat (3) step(e, 14, "halted");
    resume = 1'b1;
    step(e, 14, "halt/resume");
    resume = 1'b0;

    // Reset asserted in MEM: strobes drop at once, no partial retire, counter cleared.
    dmem_ready = 1'b0;
    front(1, 14, "lw_rst");
    step(o_alu(3'b000, 1'b1), 14, "lw_rst/exec");
    e = '0;
    e.mem_read = 1'b1;
    step(e, 14, "lw_rst/mem");
    rst_n = 1'b0;
    step('0, 0, "rst_in_mem");
    rst_n = 1'b1;
    step(o_fetch(1'b1), 0, "post_rst/fetch");

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
